decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 202 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode feeding the ID/EX pipeline register.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   if_valid/if_pc/if_instr   fetched instruction from IF
//   rs1addr/rs2addr       register-file read addresses (combinational)
//   rs1_data/rs2_data     register-file read data (combinational)
//   ex_valid/ex_memrd/ex_rdaddr    instruction currently in EX (load detection)
//   mem_regwr/mem_rdaddr/mem_result  writer in MEM (forwarding source)
//   wb_regwr/wb_rdaddr/wb_data       writer in WB (same-cycle write bypass)
//   flush                 taken branch/jump resolved downstream
//   stall_o               fetch must hold if_pc/if_instr next cycle
//   idex_*                registered ID/EX pipeline register
//
// Handshake: if_valid qualifies if_pc/if_instr in the current cycle. stall_o is
// the only back-pressure: while it is 1 the ID/EX register takes a bubble and
// fetch re-presents the same instruction next cycle. There is no ready from EX;
// the ID/EX register accepts on every edge.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic [4:0]      rs1addr,
  output logic [4:0]      rs2addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ex_valid,
  input  logic            ex_memrd,
  input  logic [4:0]      ex_rdaddr,
  input  logic            mem_regwr,
  input  logic [4:0]      mem_rdaddr,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_regwr,
  input  logic [4:0]      wb_rdaddr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            stall_o,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [31:0]     idex_instr,
  output logic [XLEN-1:0] idex_rs1val,
  output logic [XLEN-1:0] idex_rs2val,
  output logic [XLEN-1:0] idex_imm,
  output logic [4:0]      idex_rdaddr,
  output logic            idex_regwr,
  output logic            idex_memrd,
  output logic            idex_memwr
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic            rs1_used;
  logic            rs2_used;
  logic            regwr_raw;
  logic            memrd;
  logic            memwr;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rs1val;
  logic [XLEN-1:0] rs2val;
  logic            load_use;
  logic            bubble;

  assign opcode  = if_instr[6:0];
  assign rd      = if_instr[11:7];
  assign rs1addr = if_instr[19:15];
  assign rs2addr = if_instr[24:20];

  // Opcode decode: operand usage, control bits and immediate format.
  always_comb begin
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    regwr_raw = 1'b0;
    memrd     = 1'b0;
    memwr     = 1'b0;
    imm32     = 32'd0;
    case (opcode)
      OP_OP: begin
        rs2_used  = 1'b1;
        regwr_raw = 1'b1;
      end
      OP_OPIMM, OP_JALR: begin
        regwr_raw = 1'b1;
        imm32     = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OP_LOAD: begin
        regwr_raw = 1'b1;
        memrd     = 1'b1;
        imm32     = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OP_STORE: begin
        rs2_used = 1'b1;
        memwr    = 1'b1;
        imm32    = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      end
      OP_BRANCH: begin
        rs2_used = 1'b1;
        imm32    = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        rs1_used  = 1'b0;
        regwr_raw = 1'b1;
        imm32     = {if_instr[31:12], 12'd0};
      end
      OP_JAL: begin
        rs1_used  = 1'b0;
        regwr_raw = 1'b1;
        imm32     = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                     if_instr[20], if_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  // Operand source priority: x0, then MEM writer, then WB writer (the register
  // file has not absorbed the WB write yet this cycle), then the file itself.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_val,
    input logic            m_wr,
    input logic [4:0]      m_rd,
    input logic [XLEN-1:0] m_val,
    input logic            w_wr,
    input logic [4:0]      w_rd,
    input logic [XLEN-1:0] w_val
  );
    if (addr == 5'd0)                 return '0;
    else if (m_wr && (m_rd == addr))  return m_val;
    else if (w_wr && (w_rd == addr))  return w_val;
    else                              return rf_val;
  endfunction

  assign rs1val = resolve(rs1addr, rs1_data, mem_regwr, mem_rdaddr, mem_result,
                          wb_regwr, wb_rdaddr, wb_data);
  assign rs2val = resolve(rs2addr, rs2_data, mem_regwr, mem_rdaddr, mem_result,
                          wb_regwr, wb_rdaddr, wb_data);

  // Only a load in EX needs a stall; ALU results are forwarded from EX later.
  assign load_use = if_valid && ex_valid && ex_memrd && (ex_rdaddr != 5'd0) &&
                    ((rs1_used && (ex_rdaddr == rs1addr)) ||
                     (rs2_used && (ex_rdaddr == rs2addr)));

  // A flush wins so fetch is free to redirect instead of holding.
  assign stall_o = load_use && !flush;
  assign bubble  = flush || stall_o || !if_valid;

  // Bubbles clear every field so the register contents stay deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid  <= 1'b0;
      idex_pc     <= '0;
      idex_instr  <= '0;
      idex_rs1val <= '0;
      idex_rs2val <= '0;
      idex_imm    <= '0;
      idex_rdaddr <= '0;
      idex_regwr  <= 1'b0;
      idex_memrd  <= 1'b0;
      idex_memwr  <= 1'b0;
    end else if (bubble) begin
      idex_valid  <= 1'b0;
      idex_pc     <= '0;
      idex_instr  <= '0;
      idex_rs1val <= '0;
      idex_rs2val <= '0;
      idex_imm    <= '0;
      idex_rdaddr <= '0;
      idex_regwr  <= 1'b0;
      idex_memrd  <= 1'b0;
      idex_memwr  <= 1'b0;
    end else begin
      idex_valid  <= 1'b1;
      idex_pc     <= if_pc;
      idex_instr  <= if_instr;
      idex_rs1val <= rs1val;
      idex_rs2val <= rs2val;
      idex_imm    <= imm_ext;
      idex_rdaddr <= rd;
      idex_regwr  <= regwr_raw && (rd != 5'd0);
      idex_memrd  <= memrd;
      idex_memwr  <= memwr;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage with a scoreboard.
module tb_decode_stage;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic [4:0]      rs1addr, rs2addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            ex_valid, ex_memrd;
  logic [4:0]      ex_rdaddr;
  logic            mem_regwr;
  logic [4:0]      mem_rdaddr;
  logic [XLEN-1:0] mem_result;
  logic            wb_regwr;
  logic [4:0]      wb_rdaddr;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            stall_o;
  logic            idex_valid;
  logic [XLEN-1:0] idex_pc;
  logic [31:0]     idex_instr;
  logic [XLEN-1:0] idex_rs1val, idex_rs2val, idex_imm;
  logic [4:0]      idex_rdaddr;
  logic            idex_regwr, idex_memrd, idex_memwr;

  decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .rs1addr(rs1addr), .rs2addr(rs2addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_valid(ex_valid), .ex_memrd(ex_memrd), .ex_rdaddr(ex_rdaddr),
    .mem_regwr(mem_regwr), .mem_rdaddr(mem_rdaddr), .mem_result(mem_result),
    .wb_regwr(wb_regwr), .wb_rdaddr(wb_rdaddr), .wb_data(wb_data),
    .flush(flush), .stall_o(stall_o),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_instr(idex_instr),
    .idex_rs1val(idex_rs1val), .idex_rs2val(idex_rs2val), .idex_imm(idex_imm),
    .idex_rdaddr(idex_rdaddr), .idex_regwr(idex_regwr),
    .idex_memrd(idex_memrd), .idex_memwr(idex_memwr)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        regwr;
    logic        memrd;
    logic        memwr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge that the driver has scheduled.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("idex_valid", {31'd0, idex_valid}, {31'd0, e.valid});
      chk("idex_regwr", {31'd0, idex_regwr}, {31'd0, e.regwr});
      chk("idex_memrd", {31'd0, idex_memrd}, {31'd0, e.memrd});
      chk("idex_memwr", {31'd0, idex_memwr}, {31'd0, e.memwr});
      if (e.valid) begin
        chk("idex_pc",     idex_pc,     e.pc);
        chk("idex_instr",  idex_instr,  e.instr);
        chk("idex_rs1val", idex_rs1val, e.rs1);
        chk("idex_rs2val", idex_rs2val, e.rs2);
        chk("idex_imm",    idex_imm,    e.imm);
        chk("idex_rdaddr", {27'd0, idex_rdaddr}, {27'd0, e.rd});
      end
    end
  end

  // ---------------- driver tasks ----------------
  localparam logic [31:0] RF1 = 32'h1111_1111;
  localparam logic [31:0] RF2 = 32'h2222_2222;

  task automatic clear_side();
    if_valid   = 1'b0;
    if_pc      = '0;
    if_instr   = '0;
    rs1_data   = RF1;
    rs2_data   = RF2;
    ex_valid   = 1'b0;
    ex_memrd   = 1'b0;
    ex_rdaddr  = '0;
    mem_regwr  = 1'b0;
    mem_rdaddr = '0;
    mem_result = '0;
    wb_regwr   = 1'b0;
    wb_rdaddr  = '0;
    wb_data    = '0;
    flush      = 1'b0;
  endtask

  task automatic set_if(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
  endtask

  // Check the combinational stall, then schedule the expected ID/EX contents.
  task automatic issue(input string name, input logic exp_stall, input exp_t e);
    #1;
    chk(name, {31'd0, stall_o}, {31'd0, exp_stall});
    exp_q.push_back(e);
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic regwr, input logic memrd, input logic memwr);
    exp_t e;
    e.valid = 1'b1; e.pc = pc; e.instr = instr; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.rd = rd; e.regwr = regwr; e.memrd = memrd; e.memwr = memwr;
    return e;
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e = '0;
    return e;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, idex_valid}, 32'd0);
    chk({tag, "_pc"},    idex_pc,    32'd0);
    chk({tag, "_instr"}, idex_instr, 32'd0);
    chk({tag, "_rs1"},   idex_rs1val, 32'd0);
    chk({tag, "_rs2"},   idex_rs2val, 32'd0);
    chk({tag, "_imm"},   idex_imm,   32'd0);
    chk({tag, "_rd"},    {27'd0, idex_rdaddr}, 32'd0);
    chk({tag, "_ctrl"},  {29'd0, idex_regwr, idex_memrd, idex_memwr}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_side();
    #2;
    chk_all_zero("reset_init");
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Same-cycle WB bypass: ADD x1,x5,x0 with stale register file value.
    @(negedge clk); clear_side();
    set_if(32'h100, 32'h000280B3);
    rs1_data = 32'h1; wb_regwr = 1'b1; wb_rdaddr = 5'd5; wb_data = 32'hDEAD;
    issue("stall_bypass", 1'b0, mk(32'h100, 32'h000280B3, 32'hDEAD, 32'h0, 32'h0, 5'd1, 1, 0, 0));

    // MEM beats WB: ADD x8,x7,x7.
    @(negedge clk); clear_side();
    set_if(32'h104, 32'h00738433);
    rs1_data = 32'h99; rs2_data = 32'h98;
    mem_regwr = 1'b1; mem_rdaddr = 5'd7; mem_result = 32'h11;
    wb_regwr = 1'b1; wb_rdaddr = 5'd7; wb_data = 32'h22;
    issue("stall_prio", 1'b0, mk(32'h104, 32'h00738433, 32'h11, 32'h11, 32'h0, 5'd8, 1, 0, 0));

    // x0 always reads 0 even with writers targeting x0: ADD x9,x0,x0.
    @(negedge clk); clear_side();
    set_if(32'h108, 32'h000004B3);
    rs1_data = 32'h77; rs2_data = 32'h78;
    mem_regwr = 1'b1; mem_rdaddr = 5'd0; mem_result = 32'h55;
    wb_regwr = 1'b1; wb_rdaddr = 5'd0; wb_data = 32'h66;
    issue("stall_x0", 1'b0, mk(32'h108, 32'h000004B3, 32'h0, 32'h0, 32'h0, 5'd9, 1, 0, 0));

    // WB forwards on rs2 while MEM writes an unrelated register: ADD x4,x3,x2.
    @(negedge clk); clear_side();
    set_if(32'h10C, 32'h00218233);
    wb_regwr = 1'b1; wb_rdaddr = 5'd2; wb_data = 32'h77;
    mem_regwr = 1'b1; mem_rdaddr = 5'd9; mem_result = 32'h88;
    issue("stall_wb_rs2", 1'b0, mk(32'h10C, 32'h00218233, RF1, 32'h77, 32'h0, 5'd4, 1, 0, 0));

    // Load-use: LW x3 in EX, ADD x4,x3,x2 in ID.
    @(negedge clk); clear_side();
    set_if(32'h110, 32'h00218233);
    ex_valid = 1'b1; ex_memrd = 1'b1; ex_rdaddr = 5'd3;
    issue("stall_loaduse", 1'b1, bub());
    // Load has moved to MEM; its result is forwarded.
    @(negedge clk); clear_side();
    set_if(32'h110, 32'h00218233);
    mem_regwr = 1'b1; mem_rdaddr = 5'd3; mem_result = 32'h1234;
    issue("stall_after_lu", 1'b0, mk(32'h110, 32'h00218233, 32'h1234, RF2, 32'h0, 5'd4, 1, 0, 0));

    // Flush overrides load-use.
    @(negedge clk); clear_side();
    set_if(32'h114, 32'h00218233);
    ex_valid = 1'b1; ex_memrd = 1'b1; ex_rdaddr = 5'd3; flush = 1'b1;
    issue("stall_flush", 1'b0, bub());

    // BEQ x1,x2,-4.
    @(negedge clk); clear_side();
    set_if(32'h200, 32'hFE208EE3);
    issue("stall_beq", 1'b0, mk(32'h200, 32'hFE208EE3, RF1, RF2, 32'hFFFF_FFFC, 5'd29, 0, 0, 0));

    // JAL x1,+2048: rs1 field is x0.
    @(negedge clk); clear_side();
    set_if(32'h204, 32'h001000EF);
    issue("stall_jal", 1'b0, mk(32'h204, 32'h001000EF, 32'h0, RF2, 32'h0000_0800, 5'd1, 1, 0, 0));

    // LUI x5,0x12345: instr[19:15]=8 matches a load in EX, but rs1 is unused.
    @(negedge clk); clear_side();
    set_if(32'h208, 32'h123452B7);
    ex_valid = 1'b1; ex_memrd = 1'b1; ex_rdaddr = 5'd8;
    issue("stall_lui", 1'b0, mk(32'h208, 32'h123452B7, RF1, RF2, 32'h1234_5000, 5'd5, 1, 0, 0));

    // SW x2,8(x1).
    @(negedge clk); clear_side();
    set_if(32'h20C, 32'h0020A423);
    issue("stall_sw", 1'b0, mk(32'h20C, 32'h0020A423, RF1, RF2, 32'h8, 5'd8, 0, 0, 1));

    // LW x3,-16(x1).
    @(negedge clk); clear_side();
    set_if(32'h210, 32'hFF00A183);
    issue("stall_lw", 1'b0, mk(32'h210, 32'hFF00A183, RF1, RF2, 32'hFFFF_FFF0, 5'd3, 1, 1, 0));

    // ADD x0,x1,x2: regwr suppressed for rd=0.
    @(negedge clk); clear_side();
    set_if(32'h214, 32'h00208033);
    issue("stall_add_x0", 1'b0, mk(32'h214, 32'h00208033, RF1, RF2, 32'h0, 5'd0, 0, 0, 0));

    // Unknown opcode: valid passes, controls and immediate are 0.
    @(negedge clk); clear_side();
    set_if(32'h218, 32'h0020807F);
    issue("stall_unknown", 1'b0, mk(32'h218, 32'h0020807F, RF1, RF2, 32'h0, 5'd0, 0, 0, 0));

    // Load-use through rs2 of a store.
    @(negedge clk); clear_side();
    set_if(32'h21C, 32'h0020A423);
    ex_valid = 1'b1; ex_memrd = 1'b1; ex_rdaddr = 5'd2;
    issue("stall_lu_rs2", 1'b1, bub());

    // No instruction from fetch: bubble, and no stall even with a matching load.
    @(negedge clk); clear_side();
    if_instr = 32'h00218233;
    ex_valid = 1'b1; ex_memrd = 1'b1; ex_rdaddr = 5'd3;
    issue("stall_ifinvalid", 1'b0, bub());

    // Valid instruction, then asynchronous reset mid-cycle.
    @(negedge clk); clear_side();
    set_if(32'h300, 32'h000280B3);
    issue("stall_pre_rst", 1'b0, mk(32'h300, 32'h000280B3, RF1, 32'h0, 32'h0, 5'd1, 1, 0, 0));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    clear_side();
    issue("stall_post_rst", 1'b0, bub());
    @(negedge clk); clear_side();
    set_if(32'h304, 32'hFF00A183);
    issue("stall_resume", 1'b0, mk(32'h304, 32'hFF00A183, RF1, RF2, 32'hFFFF_FFF0, 5'd3, 1, 1, 0));
    @(negedge clk); clear_side();

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
